// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, control FSM states
// and the single/multi-cycle opcode classifier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative core: shift-add unsigned multiplier and restoring divider.
// One bit per cycle; hi/lo present the value the current step will produce.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic             busy;
  logic             is_div;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  assign done = busy && (count == CW'(WIDTH - 1));

  // hi_q is the partial product (MUL) or partial remainder (DIV);
  // lo_q is the multiplier being consumed or the dividend becoming the quotient.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    hi     = hi_q;
    lo     = lo_q;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    if (is_div) begin
      rem_sh = {hi_q, lo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, b_q};
      if (!diff[WIDTH]) begin
        hi = diff[WIDTH-1:0];
        lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi = rem_sh[WIDTH-1:0];
        lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      hi  = sum[WIDTH:1];
      lo  = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so each one samples the
    // pre-edge values no matter how the statements are ordered.
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      is_div <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      is_div <= (op == OP_DIV);
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
    end else if (busy) begin
      hi_q  <= hi;
      lo_q  <= lo;
      count <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with valid/ready handshake, registered result/flags
// and iterative MUL/DIV. One request in flight at a time.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  alu_op_e          op;
  alu_op_e          op_q;
  logic             accept;
  logic             div_zero;
  logic             go_calc;
  logic             iter_done;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [2*WIDTH-1:0] shl_ext;
  logic [2*WIDTH-1:0] shr_ext;
  logic [2*WIDTH-1:0] rol_ext;
  logic [2*WIDTH-1:0] ror_ext;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_c;
  logic             sc_v;

  assign op       = alu_op_e'(alu_sel);
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign div_zero = (op == OP_DIV) && (b == '0);
  assign go_calc  = accept && is_multicycle(op) && !div_zero;

  // Widened shifts: the bit just past the kept half is the last bit shifted out,
  // and is naturally 0 for a zero shift amount.
  assign sh      = b[SHW-1:0];
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign shl_ext = {{WIDTH{1'b0}}, a} << sh;
  assign shr_ext = {a, {WIDTH{1'b0}}} >> sh;
  assign rol_ext = {a, a} << sh;
  assign ror_ext = {a, a} >> sh;

  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_ext[WIDTH-1:0];
        sc_c   = add_ext[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_ext[WIDTH-1:0];
        sc_c   = sub_ext[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIV: begin
        // Only completes from here on divide-by-zero; real divides use alu_iter.
        sc_res = '1;
        sc_hi  = a;
        sc_c   = 1'b1;
      end
      OP_SHL: begin
        sc_res = shl_ext[WIDTH-1:0];
        sc_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_ext[2*WIDTH-1:WIDTH];
        sc_c   = shr_ext[WIDTH-1];
      end
      OP_ROL:  sc_res = rol_ext[2*WIDTH-1:WIDTH];
      OP_ROR:  sc_res = ror_ext[WIDTH-1:0];
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_NAND: sc_res = ~(a & b);
      OP_XNOR: sc_res = ~(a ^ b);
      OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: ;
    endcase
  end

  alu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .start(go_calc),
    .op   (op),
    .a    (a),
    .b    (b),
    .done (iter_done),
    .hi   (iter_hi),
    .lo   (iter_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op;
            if (go_calc) begin
              state <= CALC;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= sc_res;
              result_hi <= sc_hi;
              flag_c    <= sc_c;
              flag_v    <= sc_v;
              flag_z    <= (sc_res == '0);
              flag_n    <= sc_res[WIDTH-1];
            end
          end
        end
        CALC: begin
          if (iter_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= iter_lo;
            result_hi <= iter_hi;
            flag_c    <= (op_q == OP_MUL) && (iter_hi != '0);
            flag_v    <= 1'b0;
            flag_z    <= (iter_lo == '0);
            flag_n    <= iter_lo[WIDTH-1];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table at WIDTH=8 plus hand-written
// back-pressure, mid-CALC reset and WIDTH=16 sequences.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result, result_hi;
  logic [3:0] alu_sel;
  logic       flag_c, flag_z, flag_n, flag_v;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic [15:0] a_w, b_w, result_w, result_hi_w;
  logic [3:0]  alu_sel_w;
  logic        flag_c_w, flag_z_w, flag_n_w, flag_v_w;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  alu_seq #(.WIDTH(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .alu_sel(alu_sel_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .result(result_w), .result_hi(result_hi_w),
    .flag_c(flag_c_w), .flag_z(flag_z_w), .flag_n(flag_n_w), .flag_v(flag_v_w)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    alu_op_e    op;
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] cznv;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input alu_op_e vop,
                              input logic [7:0] vres, input logic [7:0] vhi,
                              input logic [3:0] vcznv, input int vlat);
    vec_t v;
    v.a = va; v.b = vb; v.op = vop; v.res = vres; v.hi = vhi; v.cznv = vcznv; v.lat = vlat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
    a = v.a; b = v.b; alu_sel = v.op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the result must come from the latched request.
    in_valid = 1'b0; a = ~v.a; b = ~v.b; alu_sel = 4'(OP_EQ);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d result", idx), 32'(result), 32'(v.res));
    check($sformatf("v%0d result_hi", idx), 32'(result_hi), 32'(v.hi));
    check($sformatf("v%0d flags_cznv", idx), 32'({flag_c, flag_z, flag_n, flag_v}), 32'(v.cznv));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("v%0d drained", idx), 32'({out_valid, in_ready}), 32'b01);
  endtask

  task automatic run_w(input string name, input logic [15:0] va, input logic [15:0] vb,
                       input alu_op_e vop, input logic [15:0] vres, input logic [15:0] vhi,
                       input logic vc, input int vlat);
    int lat;
    @(negedge clk);
    a_w = va; b_w = vb; alu_sel_w = vop; in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0; a_w = '0; b_w = '0;
    lat = 1;
    while (!out_valid_w && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(vlat));
    check({name, " result"}, 32'(result_w), 32'(vres));
    check({name, " result_hi"}, 32'(result_hi_w), 32'(vhi));
    check({name, " flag_c"}, 32'(flag_c_w), 32'(vc));
    out_ready_w = 1'b1;
    @(posedge clk); #1;
    out_ready_w = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stray;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_sel = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; a_w = '0; b_w = '0; alu_sel_w = '0;

    // Sweep a=0x0A b=0x02 over all opcodes, then corner cases.
    vecs.push_back(mk(8'h0A, 8'h02, OP_ADD,  8'h0C, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_SUB,  8'h08, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_MUL,  8'h14, 8'h00, 4'b0000, 9));
    vecs.push_back(mk(8'h0A, 8'h02, OP_DIV,  8'h05, 8'h00, 4'b0000, 9));
    vecs.push_back(mk(8'h0A, 8'h02, OP_SHL,  8'h28, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_SHR,  8'h02, 8'h00, 4'b1000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_ROL,  8'h28, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_ROR,  8'h82, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_AND,  8'h02, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_OR,   8'h0A, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_XOR,  8'h08, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_NOR,  8'hF5, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_NAND, 8'hFD, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_XNOR, 8'hF7, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_GT,   8'h01, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h0A, 8'h02, OP_EQ,   8'h00, 8'h00, 4'b0100, 1));
    vecs.push_back(mk(8'hF6, 8'h0A, OP_ADD,  8'h00, 8'h00, 4'b1100, 1));
    vecs.push_back(mk(8'h7F, 8'h01, OP_ADD,  8'h80, 8'h00, 4'b0011, 1));
    vecs.push_back(mk(8'h0A, 8'h0B, OP_SUB,  8'hFF, 8'h00, 4'b1010, 1));
    vecs.push_back(mk(8'h80, 8'h01, OP_SUB,  8'h7F, 8'h00, 4'b0001, 1));
    vecs.push_back(mk(8'h10, 8'h11, OP_MUL,  8'h10, 8'h01, 4'b1000, 9));
    vecs.push_back(mk(8'hFF, 8'hFF, OP_MUL,  8'h01, 8'hFE, 4'b1000, 9));
    vecs.push_back(mk(8'h0A, 8'h03, OP_DIV,  8'h03, 8'h01, 4'b0000, 9));
    vecs.push_back(mk(8'hFF, 8'h10, OP_DIV,  8'h0F, 8'h0F, 4'b0000, 9));
    vecs.push_back(mk(8'h07, 8'h09, OP_DIV,  8'h00, 8'h07, 4'b0100, 9));
    vecs.push_back(mk(8'h0A, 8'h00, OP_DIV,  8'hFF, 8'h0A, 4'b1010, 1));
    vecs.push_back(mk(8'h81, 8'h00, OP_SHL,  8'h81, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(8'h81, 8'h01, OP_SHL,  8'h02, 8'h00, 4'b1000, 1));
    vecs.push_back(mk(8'h81, 8'h08, OP_SHR,  8'h81, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(8'h81, 8'h01, OP_ROL,  8'h03, 8'h00, 4'b0000, 1));
    vecs.push_back(mk(8'h05, 8'h0A, OP_GT,   8'h00, 8'h00, 4'b0100, 1));
    vecs.push_back(mk(8'h5A, 8'h5A, OP_EQ,   8'h01, 8'h00, 4'b0000, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset outputs", 32'({out_valid, result, result_hi, flag_c, flag_z, flag_n, flag_v}), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready after release", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-pressure: result held, new requests refused while out_ready is low.
    @(negedge clk);
    a = 8'h0A; b = 8'h02; alu_sel = 4'(OP_ADD); in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF; alu_sel = 4'(OP_SUB);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold %0d", k),
            32'({out_valid, in_ready, result, result_hi, flag_c, flag_z, flag_n, flag_v}),
            32'({1'b1, 1'b0, 8'h0C, 8'h00, 4'b0000}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release", 32'({out_valid, in_ready}), 32'b01);

    // Reset during CALC cycle 4 of a MUL.
    @(negedge clk);
    a = 8'h10; b = 8'h11; alu_sel = 4'(OP_MUL); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid-calc no early valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid-calc reset outputs",
          32'({out_valid, in_ready, result, result_hi, flag_c, flag_z, flag_n, flag_v}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check("no partial result after reset", 32'(stray), 32'd0);
    run_vec(100, mk(8'h21, 8'h13, OP_ADD, 8'h34, 8'h00, 4'b0000, 1));

    // WIDTH=16 instance.
    run_w("w16 mul", 16'h1234, 16'h0010, OP_MUL, 16'h2340, 16'h0001, 1'b1, 17);
    run_w("w16 div", 16'hFFFF, 16'h0100, OP_DIV, 16'h00FF, 16'h00FF, 1'b0, 17);
    run_w("w16 shr", 16'h8001, 16'h000F, OP_SHR, 16'h0001, 16'h0000, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
